// File: rtl/matmul_pkg.sv
// Shared definitions for the matmul array: drain FSM states and the per-module
// result slice width shared with the multi-module wrapper.
package matmul_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } drain_state_e;

    function automatic int calc_slice_w(
        input int width_out,
        input int chunk_size,
        input int cores_a,
        input int cores_b
    );
        return width_out * chunk_size * cores_a * cores_b;
    endfunction

endpackage

// File: rtl/matmul_out_drain_if.sv
// Valid/ready stream carrying one matmul module result slice per beat.
interface matmul_out_drain_if #(
    parameter int SLICE_W = 256,
    parameter int BEAT_W  = 1
);
    logic               m_valid;
    logic               m_ready;
    logic [SLICE_W-1:0] m_data;
    logic [BEAT_W-1:0]  m_beat;
    logic               m_last;

    modport master (output m_valid, output m_data, output m_beat, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_beat, input m_last, output m_ready);
endinterface

// File: rtl/matmul_out_drain.sv
// Captures the wide matmul result bus on a rising accumulator-done edge and
// streams it out one module slice per beat, module 0 first.
module matmul_out_drain
    import matmul_pkg::*;
#(
    parameter int WIDTH_OUT     = 16,
    parameter int CHUNK_SIZE    = 4,
    parameter int NUM_CORES_A   = 4,
    parameter int NUM_CORES_B   = 1,
    parameter int TOTAL_MODULES = 2,
    localparam int SLICE_W      = calc_slice_w(WIDTH_OUT, CHUNK_SIZE, NUM_CORES_A, NUM_CORES_B),
    localparam int BUS_W        = SLICE_W * TOTAL_MODULES,
    localparam int BEAT_W       = (TOTAL_MODULES > 1) ? $clog2(TOTAL_MODULES) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     acc_done_modules,
    input  logic [BUS_W-1:0]         in_result,
    matmul_out_drain_if.master       m,
    output logic                     busy,
    output logic                     overflow
);

    localparam logic [0:0] IDLE = 1'(ST_IDLE);
    localparam logic [0:0] SEND = 1'(ST_SEND);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(TOTAL_MODULES - 1);

    logic [0:0]        state_r;
    logic              done_q_r;
    logic [BUS_W-1:0]  buf_r;
    logic [BEAT_W-1:0] beat_r;
    logic              overflow_r;
    logic              cap_s;
    logic              last_s;

    assign cap_s  = acc_done_modules & ~done_q_r;
    assign last_s = (beat_r == LAST_BEAT);

    // Stream outputs come straight from registered state; m_ready never reaches m_data.
    assign m.m_valid = (state_r == SEND);
    assign m.m_data  = buf_r[beat_r * SLICE_W +: SLICE_W];
    assign m.m_beat  = beat_r;
    assign m.m_last  = (state_r == SEND) & last_s;
    assign busy      = (state_r == SEND);
    assign overflow  = overflow_r;

    // Edge detect, capture buffer, beat counter and drain FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            done_q_r   <= 1'b0;
            buf_r      <= {BUS_W{1'b0}};
            beat_r     <= {BEAT_W{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            done_q_r <= acc_done_modules;
            case (state_r)
                IDLE: begin
                    if (cap_s) begin
                        buf_r   <= in_result;
                        beat_r  <= {BEAT_W{1'b0}};
                        state_r <= SEND;
                    end else begin
                        beat_r  <= {BEAT_W{1'b0}};
                    end
                end
                SEND: begin
                    if (m.m_ready) begin
                        if (last_s) begin
                            // A capture landing on the final beat chains directly into the next result.
                            beat_r <= {BEAT_W{1'b0}};
                            if (cap_s) begin
                                buf_r <= in_result;
                            end else begin
                                state_r <= IDLE;
                            end
                        end else begin
                            beat_r <= beat_r + BEAT_W'(1);
                            if (cap_s) begin
                                overflow_r <= 1'b1;
                            end else begin
                                overflow_r <= overflow_r;
                            end
                        end
                    end else if (cap_s) begin
                        overflow_r <= 1'b1;
                    end else begin
                        overflow_r <= overflow_r;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    beat_r  <= {BEAT_W{1'b0}};
                end
            endcase
        end
    end

endmodule
